// File: rtl/smartwatch_display_ctrl_pkg.sv
// Shared definitions for the smartwatch display controller.
// Holds the view/mode state encoding, the blank segment code and the
// number of multiplexed digits.
package smartwatch_pkg;

    typedef enum logic [2:0] {
        CLOCK     = 3'd0,
        STOPWATCH = 3'd1,
        SET_HOUR  = 3'd2,
        SET_MIN   = 3'd3,
        SET_SEC   = 3'd4
    } mode_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         NUM_DIGITS = 6;

    function automatic logic is_set(input mode_t m);
        return (m == SET_HOUR) || (m == SET_MIN) || (m == SET_SEC);
    endfunction

endpackage

// File: rtl/smartwatch_display_ctrl_if.sv
// Bundle of button inputs, digit codes and display/timekeeper outputs of
// the smartwatch display controller.
//   master: drives buttons and codes, observes display and pulses
//   slave : the controller itself
interface smartwatch_display_ctrl_if;
    logic        mode_btn;
    logic        set_btn;
    logic        inc_btn;
    logic [41:0] clk_codes;
    logic [13:0] sw_codes;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic [2:0]  mode;
    logic        inc_hour;
    logic        inc_min;
    logic        inc_sec;
    logic        set_active;

    modport master (
        output mode_btn, set_btn, inc_btn, clk_codes, sw_codes,
        input  seg, an, mode, inc_hour, inc_min, inc_sec, set_active
    );

    modport slave (
        input  mode_btn, set_btn, inc_btn, clk_codes, sw_codes,
        output seg, an, mode, inc_hour, inc_min, inc_sec, set_active
    );
endinterface

// File: rtl/smartwatch_display_ctrl_tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick every DIV
// cycles (on the last count value).
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : synchronously zeroes the count
//   tick         : high while the count is DIV-1
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/smartwatch_display_ctrl.sv
// Smartwatch six-digit seven-segment display sequencer.
// A mode FSM selects clock / stopwatch / time-set view and emits increment
// pulses; a scan divider multiplexes per-digit codes onto one segment bus.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : buttons, clock/stopwatch codes in; seg, an, mode,
//                  inc_hour/min/sec, set_active out
module smartwatch_display_ctrl
    import smartwatch_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    smartwatch_display_ctrl_if.slave bus
);
    mode_t       state_q, state_d;
    logic        inc_hour_q, inc_hour_d;
    logic        inc_min_q, inc_min_d;
    logic        inc_sec_q, inc_sec_d;
    logic        set_active_q;
    logic [2:0]  digit_q, digit_d;
    logic        blink_phase_q, blink_phase_d;
    logic [6:0]  seg_q, seg_d;
    logic [5:0]  an_q, an_d;
    logic        scan_tick, blink_tick, blink_clr;

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk(clk), .reset_n(reset_n), .clr(1'b0), .tick(scan_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk(clk), .reset_n(reset_n), .clr(blink_clr), .tick(blink_tick)
    );

    // Mode FSM: mode_btn outranks set_btn, which outranks inc_btn.
    always_comb begin
        state_d    = state_q;
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        inc_sec_d  = 1'b0;
        if (bus.mode_btn) begin
            state_d = (state_q == CLOCK) ? STOPWATCH : CLOCK;
        end else if (bus.set_btn) begin
            case (state_q)
                CLOCK:    state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = CLOCK;
                default:  state_d = state_q;
            endcase
        end else if (bus.inc_btn) begin
            inc_hour_d = (state_q == SET_HOUR);
            inc_min_d  = (state_q == SET_MIN);
            inc_sec_d  = (state_q == SET_SEC);
        end
    end

    // Restart blinking on every entry into a set field so it shows at once.
    assign blink_clr = is_set(state_d) && (state_d != state_q);

    always_comb begin
        digit_d = digit_q;
        if (scan_tick) digit_d = (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
        blink_phase_d = blink_phase_q;
        if (blink_clr)       blink_phase_d = 1'b0;
        else if (blink_tick) blink_phase_d = ~blink_phase_q;
    end

    // Digit content for the currently scanned digit.
    always_comb begin
        seg_d = bus.clk_codes[7*int'(digit_q) +: 7];
        if (state_q == STOPWATCH) begin
            seg_d = SEG_BLANK;
            if (digit_q < 3'd2) seg_d = bus.sw_codes[7*int'(digit_q[0]) +: 7];
        end
        // Digit pair index: sec = 0, min = 1, hour = 2 (== 4 - state code).
        if (is_set(state_q) && blink_phase_q &&
            (digit_q[2:1] == 2'(3'd4 - 3'(state_q))))
            seg_d = SEG_BLANK;
        an_d = ~(6'b000001 << digit_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= CLOCK;
            inc_hour_q    <= 1'b0;
            inc_min_q     <= 1'b0;
            inc_sec_q     <= 1'b0;
            set_active_q  <= 1'b0;
            digit_q       <= 3'd0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= 6'h3F;
        end else begin
            state_q       <= state_d;
            inc_hour_q    <= inc_hour_d;
            inc_min_q     <= inc_min_d;
            inc_sec_q     <= inc_sec_d;
            set_active_q  <= is_set(state_d);
            digit_q       <= digit_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.mode       = state_q;
    assign bus.inc_hour   = inc_hour_q;
    assign bus.inc_min    = inc_min_q;
    assign bus.inc_sec    = inc_sec_q;
    assign bus.set_active = set_active_q;
endmodule
